// File: rtl/valid_alloc_pkg.sv
// Shared definitions for the valid-way allocator: FSM state encoding and
// the one-hot seed used when turning a way index into a one-hot select.
package valid_alloc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_RESP   = 3'd3,
    ST_COMMIT = 3'd4
  } alloc_state_e;

  localparam int unsigned STATE_W     = 3;
  localparam logic        ONEHOT_SEED = 1'b1;

endpackage

// File: rtl/find_first_zero_onehot.sv
// Combinational picker: one-hot of the lowest-index zero bit of vec_in,
// plus a flag when every bit is set (onehot_out is then all zeros).
module find_first_zero_onehot #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] vec_in,
  output logic [WIDTH-1:0] onehot_out,
  output logic             all_ones_out
);

  logic [WIDTH-1:0] inverted;

  // Isolate the lowest set bit of the inverted vector (x & -x).
  assign inverted     = ~vec_in;
  assign onehot_out   = inverted & (~inverted + 1'b1);
  assign all_ones_out = &vec_in;

endmodule

// File: rtl/valid_way_allocator.sv
// Set-allocation front end for the per-way valid array: read a set, pick the
// lowest invalid way or a round-robin victim, return it, then mark it valid.
// Optional stats counters are built when VALID_ALLOC_STATS_EN is defined.
module valid_way_allocator
  import valid_alloc_pkg::*;
#(
  parameter int NUMBER_SET            = 64,
  parameter int NUMBER_WAY            = 16,
  parameter int SET_PTR_WIDTH_IN_BITS = $clog2(NUMBER_SET),
  parameter int WAY_PTR_WIDTH_IN_BITS = $clog2(NUMBER_WAY)
) (
  input  logic                             clk_in,
  input  logic                             reset_in,
  input  logic                             alloc_req_valid_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0] alloc_req_set_in,
  output logic                             alloc_req_ready_out,
  output logic                             alloc_resp_valid_out,
  output logic [NUMBER_WAY-1:0]            alloc_resp_way_out,
  output logic                             alloc_resp_evict_out,
  input  logic                             alloc_resp_ready_in,
  output logic                             array_access_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0] array_access_set_addr_out,
  output logic                             array_write_en_out,
  output logic [NUMBER_WAY-1:0]            array_write_way_select_out,
  input  logic [NUMBER_WAY-1:0]            array_read_set_valid_in,
`ifdef VALID_ALLOC_STATS_EN
  output logic [31:0]                      alloc_count_out,
  output logic [31:0]                      evict_count_out,
`endif
  output alloc_state_e                     fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; the sender holds its payload steady while valid is 1 and ready 0.

  alloc_state_e state_q, state_d;

  logic [SET_PTR_WIDTH_IN_BITS-1:0] set_q;
  logic [NUMBER_WAY-1:0]            way_q;
  logic                             evict_q;
  logic [WAY_PTR_WIDTH_IN_BITS-1:0] rr_ptr_q [NUMBER_SET];

  logic [WAY_PTR_WIDTH_IN_BITS-1:0] rr_cur;
  logic [WAY_PTR_WIDTH_IN_BITS-1:0] rr_next;
  logic [NUMBER_WAY-1:0]            rr_onehot;
  logic [NUMBER_WAY-1:0]            free_onehot;
  logic                             set_full;

  find_first_zero_onehot #(
    .WIDTH(NUMBER_WAY)
  ) u_ffz (
    .vec_in      (array_read_set_valid_in),
    .onehot_out  (free_onehot),
    .all_ones_out(set_full)
  );

  assign rr_cur    = rr_ptr_q[set_q];
  assign rr_onehot = {{(NUMBER_WAY-1){1'b0}}, ONEHOT_SEED} << rr_cur;
  assign rr_next   = (rr_cur == WAY_PTR_WIDTH_IN_BITS'(NUMBER_WAY - 1))
                     ? '0 : rr_cur + 1'b1;
  assign fsm_state = state_q;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d                    = state_q;
    alloc_req_ready_out        = 1'b0;
    alloc_resp_valid_out       = 1'b0;
    alloc_resp_way_out         = '0;
    alloc_resp_evict_out       = 1'b0;
    array_access_en_out        = 1'b0;
    array_access_set_addr_out  = '0;
    array_write_en_out         = 1'b0;
    array_write_way_select_out = '0;
    case (state_q)
      ST_IDLE: begin
        alloc_req_ready_out = 1'b1;
        if (alloc_req_valid_in) state_d = ST_READ;
      end
      ST_READ: begin
        // All ways selected; the array gates the read per way itself.
        array_access_en_out        = 1'b1;
        array_access_set_addr_out  = set_q;
        array_write_way_select_out = '1;
        state_d                    = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        alloc_resp_valid_out = 1'b1;
        alloc_resp_way_out   = way_q;
        alloc_resp_evict_out = evict_q;
        if (alloc_resp_ready_in) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        array_access_en_out        = 1'b1;
        array_access_set_addr_out  = set_q;
        array_write_en_out         = 1'b1;
        array_write_way_select_out = way_q;
        state_d                    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      set_q   <= '0;
      way_q   <= '0;
      evict_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && alloc_req_valid_in) set_q <= alloc_req_set_in;
      if (state_q == ST_SAMPLE) begin
        way_q   <= set_full ? rr_onehot : free_onehot;
        evict_q <= set_full;
      end
    end
  end

  // Victim pointer advances only when a full set actually loses a way.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < NUMBER_SET; i++) rr_ptr_q[i] <= '0;
    end else if (state_q == ST_COMMIT && evict_q) begin
      rr_ptr_q[set_q] <= rr_next;
    end
  end

`ifdef VALID_ALLOC_STATS_EN
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      alloc_count_out <= '0;
      evict_count_out <= '0;
    end else if (state_q == ST_COMMIT) begin
      if (alloc_count_out != '1) alloc_count_out <= alloc_count_out + 1'b1;
      if (evict_q && evict_count_out != '1) evict_count_out <= evict_count_out + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_valid_way_allocator.sv
// Bench for valid_way_allocator: behavioural valid array, scoreboard of
// expected {evict, way}, directed scenarios plus a randomised sweep.
module tb_valid_way_allocator;

  localparam int NS = 64;
  localparam int NW = 16;
  localparam int SW = 6;

  logic          clk_in = 1'b0;
  logic          reset_in = 1'b1;
  logic          alloc_req_valid_in = 1'b0;
  logic [SW-1:0] alloc_req_set_in = '0;
  logic          alloc_req_ready_out;
  logic          alloc_resp_valid_out;
  logic [NW-1:0] alloc_resp_way_out;
  logic          alloc_resp_evict_out;
  logic          alloc_resp_ready_in = 1'b0;
  logic          array_access_en_out;
  logic [SW-1:0] array_access_set_addr_out;
  logic          array_write_en_out;
  logic [NW-1:0] array_write_way_select_out;
  logic [NW-1:0] array_read_set_valid_in = '0;
  logic [2:0]    fsm_state;
`ifdef VALID_ALLOC_STATS_EN
  logic [31:0]   alloc_count_out;
  logic [31:0]   evict_count_out;
`endif

  logic [NW-1:0] mem [NS];
  int unsigned   rr_model [NS];
  logic [NW:0]   exp_q [$];
  int            total = 0;
  int            bad = 0;
  int            write_count = 0;
  int            model_allocs = 0;
  int            model_evicts = 0;

  valid_way_allocator dut (
    .clk_in                    (clk_in),
    .reset_in                  (reset_in),
    .alloc_req_valid_in        (alloc_req_valid_in),
    .alloc_req_set_in          (alloc_req_set_in),
    .alloc_req_ready_out       (alloc_req_ready_out),
    .alloc_resp_valid_out      (alloc_resp_valid_out),
    .alloc_resp_way_out        (alloc_resp_way_out),
    .alloc_resp_evict_out      (alloc_resp_evict_out),
    .alloc_resp_ready_in       (alloc_resp_ready_in),
    .array_access_en_out       (array_access_en_out),
    .array_access_set_addr_out (array_access_set_addr_out),
    .array_write_en_out        (array_write_en_out),
    .array_write_way_select_out(array_write_way_select_out),
    .array_read_set_valid_in   (array_read_set_valid_in),
`ifdef VALID_ALLOC_STATS_EN
    .alloc_count_out           (alloc_count_out),
    .evict_count_out           (evict_count_out),
`endif
    .fsm_state                 (fsm_state)
  );

  // Clock and watchdog
  always #5 clk_in = ~clk_in;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Valid array model: read data appears the cycle after a read access
  always @(posedge clk_in) begin
    if (array_access_en_out && !array_write_en_out)
      array_read_set_valid_in <= mem[array_access_set_addr_out];
    if (array_write_en_out) write_count <= write_count + 1;
  end

  function automatic logic [NW:0] predict(input int s);
    logic [NW-1:0] one;
    one = 1;
    for (int i = 0; i < NW; i++)
      if (!mem[s][i]) return {1'b0, one << i};
    return {1'b1, one << rr_model[s]};
  endfunction

  task automatic check_idle_outputs(input string tag);
    total++;
    if (alloc_req_ready_out !== 1'b1 || alloc_resp_valid_out !== 1'b0 ||
        alloc_resp_way_out !== '0 || alloc_resp_evict_out !== 1'b0 ||
        array_access_en_out !== 1'b0 || array_write_en_out !== 1'b0 ||
        array_access_set_addr_out !== '0 || array_write_way_select_out !== '0 ||
        fsm_state !== 3'd0) begin
      bad++;
      $display("FAIL %s: rdy=%b rv=%b way=%h ev=%b en=%b we=%b addr=%0d sel=%h st=%0d required rdy=1 rest=0",
               tag, alloc_req_ready_out, alloc_resp_valid_out, alloc_resp_way_out,
               alloc_resp_evict_out, array_access_en_out, array_write_en_out,
               array_access_set_addr_out, array_write_way_select_out, fsm_state);
    end
  endtask

  // Driver for one full allocation; hold = cycles resp_ready stays low
  task automatic do_alloc(input int s, input int hold);
    logic [NW:0]   exp;
    logic [NW-1:0] w_seen;
    logic          e_seen;
    int            k;
    int            wc0;
    @(negedge clk_in);
    total++;
    if (alloc_req_ready_out !== 1'b1) begin
      bad++;
      $display("FAIL req_ready: got=%b required=1", alloc_req_ready_out);
    end
    exp_q.push_back(predict(s));
    alloc_req_valid_in = 1'b1;
    alloc_req_set_in   = SW'(s);
    @(posedge clk_in);
    #1 alloc_req_valid_in = 1'b0;
    k = 0;
    while (k < 10) begin
      @(negedge clk_in);
      k++;
      if (alloc_resp_valid_out) break;
      if (k == 1) begin
        total++;
        if (array_access_en_out !== 1'b1 || array_write_en_out !== 1'b0 ||
            array_write_way_select_out !== '1 || array_access_set_addr_out !== SW'(s)) begin
          bad++;
          $display("FAIL read_cycle: en=%b we=%b sel=%h addr=%0d required en=1 we=0 sel=ffff addr=%0d",
                   array_access_en_out, array_write_en_out, array_write_way_select_out,
                   array_access_set_addr_out, s);
        end
      end
      if (k == 2) begin
        total++;
        if (array_access_en_out !== 1'b0 || array_write_en_out !== 1'b0 || alloc_req_ready_out !== 1'b0) begin
          bad++;
          $display("FAIL sample_cycle: en=%b we=%b rdy=%b required all 0",
                   array_access_en_out, array_write_en_out, alloc_req_ready_out);
        end
      end
    end
    total++;
    if (alloc_resp_valid_out !== 1'b1 || k != 3) begin
      bad++;
      $display("FAIL resp_latency: cycles=%0d valid=%b required cycles=3 valid=1", k, alloc_resp_valid_out);
    end
    if (alloc_resp_valid_out !== 1'b1) begin
      void'(exp_q.pop_front());
      return;
    end
    w_seen = alloc_resp_way_out;
    e_seen = alloc_resp_evict_out;
    wc0    = write_count;
    repeat (hold) begin
      @(negedge clk_in);
      total++;
      if (alloc_resp_valid_out !== 1'b1 || alloc_resp_way_out !== w_seen ||
          alloc_resp_evict_out !== e_seen || alloc_req_ready_out !== 1'b0 ||
          array_access_en_out !== 1'b0 || array_write_en_out !== 1'b0) begin
        bad++;
        $display("FAIL resp_hold: rv=%b way=%h ev=%b rdy=%b en=%b we=%b required rv=1 way=%h ev=%b rdy=0 en=0 we=0",
                 alloc_resp_valid_out, alloc_resp_way_out, alloc_resp_evict_out,
                 alloc_req_ready_out, array_access_en_out, array_write_en_out, w_seen, e_seen);
      end
    end
    exp = exp_q.pop_front();
    total++;
    if ({alloc_resp_evict_out, alloc_resp_way_out} !== exp) begin
      bad++;
      $display("FAIL resp set=%0d: evict=%b way=%h required evict=%b way=%h",
               s, alloc_resp_evict_out, alloc_resp_way_out, exp[NW], exp[NW-1:0]);
    end
    alloc_resp_ready_in = 1'b1;
    @(posedge clk_in);
    #1 alloc_resp_ready_in = 1'b0;
    @(negedge clk_in);
    total++;
    if (array_access_en_out !== 1'b1 || array_write_en_out !== 1'b1 ||
        array_write_way_select_out !== exp[NW-1:0] || array_access_set_addr_out !== SW'(s)) begin
      bad++;
      $display("FAIL commit: en=%b we=%b sel=%h addr=%0d required en=1 we=1 sel=%h addr=%0d",
               array_access_en_out, array_write_en_out, array_write_way_select_out,
               array_access_set_addr_out, exp[NW-1:0], s);
    end
    mem[s] = mem[s] | exp[NW-1:0];
    if (exp[NW]) begin
      rr_model[s] = (rr_model[s] + 1) % NW;
      model_evicts++;
    end
    model_allocs++;
    @(negedge clk_in);
    total++;
    if (write_count != wc0 + 1 || alloc_req_ready_out !== 1'b1 || array_access_en_out !== 1'b0) begin
      bad++;
      $display("FAIL write_once: writes=%0d rdy=%b en=%b required writes=%0d rdy=1 en=0",
               write_count - wc0, alloc_req_ready_out, array_access_en_out, 1);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_in);
    check_idle_outputs("reset_held");
    reset_in = 1'b0;
    @(negedge clk_in);
    check_idle_outputs("reset_released");
  endtask

  task automatic test_first_free();
    mem[5] = '0;
    do_alloc(5, 0);
    mem[3] = 16'h00FF;
    do_alloc(3, 1);
    mem[3] = '1;
    do_alloc(3, 0);
  endtask

  task automatic test_round_robin();
    mem[7] = '1;
    repeat (3) do_alloc(7, 0);
    mem[8] = '1;
    do_alloc(8, 0);
  endtask

  task automatic test_back_pressure();
    mem[20] = 16'h7FFF;
    do_alloc(20, 5);
    do_alloc(20, 2);
  endtask

  task automatic test_reset_mid_resp();
    int wc0;
    mem[7] = '1;
    @(negedge clk_in);
    alloc_req_valid_in = 1'b1;
    alloc_req_set_in   = SW'(7);
    @(posedge clk_in);
    #1 alloc_req_valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
    total++;
    if (alloc_resp_valid_out !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_resp: valid=%b required=1", alloc_resp_valid_out);
    end
    wc0 = write_count;
    alloc_resp_ready_in = 1'b1;
    #1 reset_in = 1'b1;
    #1 check_idle_outputs("reset_async");
    @(negedge clk_in);
    alloc_resp_ready_in = 1'b0;
    reset_in = 1'b0;
    for (int i = 0; i < NS; i++) rr_model[i] = 0;
    repeat (2) @(negedge clk_in);
    total++;
    if (write_count != wc0) begin
      bad++;
      $display("FAIL reset_no_write: writes=%0d required=0", write_count - wc0);
    end
    do_alloc(7, 0);
  endtask

  task automatic test_random();
    int s;
    repeat (24) begin
      s = $urandom_range(0, NS - 1);
      if ($urandom_range(0, 2) == 0) mem[s] = '1;
      else mem[s] = NW'($urandom);
      do_alloc(s, $urandom_range(0, 3));
    end
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      mem[i]      = '0;
      rr_model[i] = 0;
    end
    test_reset();
    test_first_free();
    test_round_robin();
    test_back_pressure();
    test_reset_mid_resp();
    test_random();
`ifdef VALID_ALLOC_STATS_EN
    total++;
    if (alloc_count_out !== 32'(model_allocs) || evict_count_out !== 32'(model_evicts)) begin
      bad++;
      $display("FAIL stats: alloc=%0d evict=%0d required alloc=%0d evict=%0d",
               alloc_count_out, evict_count_out, model_allocs, model_evicts);
    end
`endif
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: left=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
